pcpi_issuer: RTL and testbench
==============================

Name: pcpi_issuer

Overview:
PCPI initiator for the M-extension/custom-instruction coprocessor. It plays the core side of the interface so the coprocessor can be driven standalone, from a test harness or from a small sequencer.
- Accepts one instruction plus operands on a valid/ready command port.
- Drives pcpi_valid/insn/rs1/rs2 and waits for pcpi_ready.
- Applies a no-claim timeout and a hung-busy watchdog.
- Returns result, write flag, error flag and latency on a valid/ready response port.

Parameters:
TIMEOUT_CYCLES, 16, cycles pcpi_valid may stay high with pcpi_busy low and no pcpi_ready before the instruction is treated as unclaimed (min 2)
WDOG_CYCLES, 1024, max cycles in BUSY before error; 0 disables the watchdog
CYC_W, 16, width of the latency count (saturating)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  issuer can accept a command
cmd_insn  in  32  instruction word
cmd_rs1  in  32  operand 1
cmd_rs2  in  32  operand 2
pcpi_valid  out  1  instruction presented to the coprocessor
pcpi_insn  out  32  registered instruction
pcpi_rs1  out  32  registered operand 1
pcpi_rs2  out  32  registered operand 2
pcpi_wr  in  1  coprocessor writes rd
pcpi_rd  in  32  coprocessor result
pcpi_busy  in  1  coprocessor has claimed the instruction
pcpi_ready  in  1  coprocessor done (single-cycle pulse)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  32  result
rsp_wr  out  1  captured pcpi_wr
rsp_err  out  1  timeout or watchdog expiry
rsp_cycles  out  CYC_W  cycles from pcpi_valid rise to completion, saturating

Behaviour:
- Clock and reset: single clock clk; reset resetn is asynchronous active-low. In reset:
  - state = IDLE.
  - pcpi_valid, rsp_valid, rsp_wr, rsp_err = 0.
  - pcpi_insn/rs1/rs2, rsp_data, rsp_cycles = 0.
  - cmd_ready = 0 while resetn is low.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch insn/rs1/rs2, pcpi_valid <= 1, counters cleared, go to ISSUE.
- ISSUE (pcpi_valid = 1, cycle counter increments each cycle):
  - pcpi_ready: capture the result and go to RESP.
  - Else pcpi_busy: go to BUSY, watchdog counter cleared.
  - Else counter reaches TIMEOUT_CYCLES-1: go to RESP with rsp_err = 1.
- BUSY (pcpi_valid stays 1):
  - pcpi_ready: capture the result and go to RESP.
  - Else WDOG_CYCLES != 0 and watchdog reaches WDOG_CYCLES-1: go to RESP with rsp_err = 1.
  - pcpi_busy dropping without pcpi_ready: stay in BUSY.
- Capturing on pcpi_ready:
  - rsp_wr <= pcpi_wr.
  - rsp_data <= pcpi_wr ? pcpi_rd : 0.
  - rsp_err <= 0.
  - rsp_cycles <= counter + 1 (saturating).
- Error exits: rsp_data = 0, rsp_wr = 0.
- Simultaneous events: pcpi_ready has priority over timeout/watchdog in the same cycle.
- pcpi_valid deassertion: pcpi_valid is cleared at the same edge that enters RESP, so it is low the cycle after pcpi_ready is sampled. The coprocessor returns to IDLE after its one-cycle DONE and must not see a re-issue.
- Operand stability: pcpi_insn/rs1/rs2 are stable for the whole time pcpi_valid is high, and hold their values afterwards.
- RESP:
  - rsp_valid = 1; rsp_* are stable until rsp_valid && rsp_ready.
  - On the handshake: go to IDLE. cmd_ready rises the following cycle (no bypass), so throughput is at most one instruction per (latency + 2) cycles.
- pcpi_ready, pcpi_busy or pcpi_wr seen in IDLE or RESP: ignored.
- Minimum latency: cmd accept at edge N → pcpi_valid high from N. A responder with a 1-cycle decode plus DONE gives pcpi_ready at N+2 and rsp_valid from N+3.
- Reset mid-operation: pcpi_valid drops asynchronously; any in-flight response is discarded.

Optional Feature:
PCPI_ISSUER_STATS_EN
- Defined: adds outputs stat_issued[31:0], stat_timeouts[15:0] and stat_busy_cycles[31:0]. All are wrapping counters, reset to 0.
  - stat_issued increments per accepted command.
  - stat_timeouts increments per error exit.
  - stat_busy_cycles increments for each cycle spent in BUSY.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header (alongside m_definitions.svh) holds:
  - the issuer state enum;
  - the default TIMEOUT/WDOG constants;
  - the M-extension encodings used by the bench (OPCODE, FUNC7, OPCODE_CUSTOM, func3 values).
- One sub-module, pcpi_watchdog: clear/enable inputs, saturating count, and expiry compare against a limit input. Instantiated twice (timeout and watchdog).

Test Plan:
1. MUL: cmd_insn = 0x02C58533, rs1 = 7, rs2 = 6, against the real coprocessor → rsp_data = 42, rsp_wr = 1, rsp_err = 0. pcpi_valid is low the cycle after pcpi_ready.
2. DIV: cmd_insn = 0x02C5C533, rs1 = 0xFFFFFF9C (-100), rs2 = 7 → rsp_data = 0xFFFFFFF2 (-14), rsp_wr = 1, rsp_cycles ≥ 34 (32 divide iterations plus select/done).
3. Unclaimed instruction: cmd_insn = 0x00C58533 (ADD, funct7 = 0), no busy/ready → rsp_err = 1, rsp_data = 0, rsp_cycles = TIMEOUT_CYCLES, exactly TIMEOUT_CYCLES cycles of pcpi_valid.
4. Hung responder model: pcpi_busy stuck high, WDOG_CYCLES = 64 → rsp_err = 1 after 64 BUSY cycles. Repeat with pcpi_ready in the expiry cycle → rsp_err = 0 and the result is captured.
5. Backpressure: rsp_ready low for 10 cycles after a MUL completes → rsp_* stable and cmd_ready = 0 throughout. The command is accepted only the cycle after the handshake.
6. Assert resetn low while in BUSY during a DIV → pcpi_valid = 0 immediately. After release, a new MUL (3 × 5) returns 15 with no stale response.

Source files
------------

// File: rtl/pcpi_issuer_pkg.sv
// Shared definitions for the PCPI issuer.
// Holds the issuer state encoding, the default no-claim timeout and watchdog limits, and the
// RV32M / custom-0 encodings that drivers and benches use to build instruction words.
package pcpi_issuer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StResp
  } issuer_state_e;

  localparam int unsigned DefTimeoutCycles = 16;
  localparam int unsigned DefWdogCycles    = 1024;

  // RV32M lives in the OP major opcode with funct7 = 1; custom-0 carries accelerator ops.
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeCustom = 7'b0001011;
  localparam logic [6:0] Func7MulDiv  = 7'b0000001;

  localparam logic [2:0] Func3Mul    = 3'b000;
  localparam logic [2:0] Func3Mulh   = 3'b001;
  localparam logic [2:0] Func3Mulhsu = 3'b010;
  localparam logic [2:0] Func3Mulhu  = 3'b011;
  localparam logic [2:0] Func3Div    = 3'b100;
  localparam logic [2:0] Func3Divu   = 3'b101;
  localparam logic [2:0] Func3Rem    = 3'b110;
  localparam logic [2:0] Func3Remu   = 3'b111;

endpackage

// File: rtl/pcpi_watchdog.sv
// Saturating cycle counter with an expiry compare.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   clear        synchronous clear to zero (wins over enable)
//   enable       count one cycle
//   limit        expiry value compared against the current count
//   count        current count, sticks at all-ones
//   expired      count == limit (combinational)
module pcpi_watchdog #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] count,
  output logic             expired
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == limit);

endmodule

// File: rtl/pcpi_issuer.sv
// PCPI initiator: plays the core side of the PCPI interface so a coprocessor can be driven
// standalone. One command in, one response out, with a no-claim timeout and a hung-busy watchdog.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   cmd_valid/ready/insn/rs1/rs2     command port (valid/ready)
//   pcpi_valid/insn/rs1/rs2          instruction presented to the coprocessor
//   pcpi_wr/rd/busy/ready            coprocessor reply
//   rsp_valid/ready/data/wr/err      response port (valid/ready)
//   rsp_cycles                       cycles from pcpi_valid rise to completion, saturating
// Optional: define PCPI_ISSUER_STATS_EN to add stat_issued, stat_timeouts, stat_busy_cycles.
module pcpi_issuer
  import pcpi_issuer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned WDOG_CYCLES    = DefWdogCycles,
  parameter int unsigned CYC_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_insn,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_busy,
  input  logic             pcpi_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_wr,
  output logic             rsp_err,
  output logic [CYC_W-1:0] rsp_cycles
`ifdef PCPI_ISSUER_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [15:0]      stat_timeouts,
  output logic [31:0]      stat_busy_cycles
`endif
);

  localparam int unsigned WdogW = 32;
  localparam logic [CYC_W-1:0] TimeoutLimit = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam bit WdogEn = (WDOG_CYCLES != 0);
  localparam logic [WdogW-1:0] WdogLimit = WdogEn ? WdogW'(WDOG_CYCLES - 1) : '0;

  issuer_state_e state_q, state_d;

  logic        pcpi_valid_q;
  logic [31:0] insn_q, rs1_q, rs2_q;
  logic [31:0] rsp_data_q;
  logic        rsp_wr_q, rsp_err_q;
  logic [CYC_W-1:0] rsp_cycles_q;

  logic accept, capture, err_exit;
  logic cyc_clear, cyc_en, wd_clear, wd_en;
  logic [CYC_W-1:0] cyc_count;
  logic             cyc_expired;
  logic [WdogW-1:0] wd_count;
  logic             wd_expired;
  logic [CYC_W:0]   cyc_inc;
  logic [CYC_W-1:0] cyc_sat;
  logic             unused_wd_count;

  // Cycle counter: runs from pcpi_valid rise through ISSUE and BUSY; its expiry is the
  // no-claim timeout and only matters while still in ISSUE.
  pcpi_watchdog #(
    .Width(CYC_W)
  ) u_cyc_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cyc_clear),
    .enable (cyc_en),
    .limit  (TimeoutLimit),
    .count  (cyc_count),
    .expired(cyc_expired)
  );

  // Hung-busy watchdog: restarts on the ISSUE->BUSY transition.
  pcpi_watchdog #(
    .Width(WdogW)
  ) u_wdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (wd_clear),
    .enable (wd_en),
    .limit  (WdogLimit),
    .count  (wd_count),
    .expired(wd_expired)
  );

  assign unused_wd_count = ^wd_count;

  // Reported latency counts the completing cycle itself.
  assign cyc_inc = {1'b0, cyc_count} + (CYC_W + 1)'(1);
  assign cyc_sat = cyc_inc[CYC_W] ? {CYC_W{1'b1}} : cyc_inc[CYC_W-1:0];

  assign cmd_ready = resetn && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    err_exit  = 1'b0;
    cyc_clear = 1'b0;
    cyc_en    = 1'b0;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          cyc_clear = 1'b1;
          wd_clear  = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        cyc_en = 1'b1;
        // ready beats busy beats timeout
        if (pcpi_ready) begin
          capture = 1'b1;
          state_d = StResp;
        end else if (pcpi_busy) begin
          wd_clear = 1'b1;
          state_d  = StBusy;
        end else if (cyc_expired) begin
          err_exit = 1'b1;
          state_d  = StResp;
        end
      end
      StBusy: begin
        cyc_en = 1'b1;
        wd_en  = 1'b1;
        // busy dropping without ready is tolerated; only ready or the watchdog leave
        if (pcpi_ready) begin
          capture = 1'b1;
          state_d = StResp;
        end else if (WdogEn && wd_expired) begin
          err_exit = 1'b1;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      pcpi_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rsp_data_q   <= '0;
      rsp_wr_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        insn_q       <= cmd_insn;
        rs1_q        <= cmd_rs1;
        rs2_q        <= cmd_rs2;
        pcpi_valid_q <= 1'b1;
      end
      // pcpi_valid falls on the RESP-entry edge so the coprocessor never sees a re-issue.
      if (capture) begin
        pcpi_valid_q <= 1'b0;
        rsp_wr_q     <= pcpi_wr;
        rsp_data_q   <= pcpi_wr ? pcpi_rd : 32'd0;
        rsp_err_q    <= 1'b0;
        rsp_cycles_q <= cyc_sat;
      end
      if (err_exit) begin
        pcpi_valid_q <= 1'b0;
        rsp_wr_q     <= 1'b0;
        rsp_data_q   <= 32'd0;
        rsp_err_q    <= 1'b1;
        rsp_cycles_q <= cyc_sat;
      end
    end
  end

  assign pcpi_valid = pcpi_valid_q;
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_data   = rsp_data_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cycles = rsp_cycles_q;

`ifdef PCPI_ISSUER_STATS_EN
  logic [31:0] issued_q, busy_cycles_q;
  logic [15:0] timeouts_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issued_q      <= '0;
      timeouts_q    <= '0;
      busy_cycles_q <= '0;
    end else begin
      if (accept) begin
        issued_q <= issued_q + 32'd1;
      end
      if (err_exit) begin
        timeouts_q <= timeouts_q + 16'd1;
      end
      if (state_q == StBusy) begin
        busy_cycles_q <= busy_cycles_q + 32'd1;
      end
    end
  end

  assign stat_issued      = issued_q;
  assign stat_timeouts    = timeouts_q;
  assign stat_busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_pcpi_issuer.sv
// Self-checking bench for pcpi_issuer. The bench plays the coprocessor cycle by cycle and
// predicts each outcome from cycle indices: claim cycle, ready cycle, timeout and watchdog limits.
module tb_pcpi_issuer;
  import pcpi_issuer_pkg::*;

  localparam int T  = 16;
  localparam int W  = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_insn, cmd_rs1, cmd_rs2;
  logic          pcpi_valid;
  logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic          pcpi_wr, pcpi_busy, pcpi_ready;
  logic [31:0]   pcpi_rd;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_wr, rsp_err;
  logic [CW-1:0] rsp_cycles;
`ifdef PCPI_ISSUER_STATS_EN
  logic [31:0]   stat_issued, stat_busy_cycles;
  logic [15:0]   stat_timeouts;
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_tag = "init";

  always #5 clk = ~clk;

  pcpi_issuer #(
    .TIMEOUT_CYCLES(T),
    .WDOG_CYCLES   (W),
    .CYC_W         (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_insn  (cmd_insn),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_rs1  (pcpi_rs1),
    .pcpi_rs2  (pcpi_rs2),
    .pcpi_wr   (pcpi_wr),
    .pcpi_rd   (pcpi_rd),
    .pcpi_busy (pcpi_busy),
    .pcpi_ready(pcpi_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_wr    (rsp_wr),
    .rsp_err   (rsp_err),
    .rsp_cycles(rsp_cycles)
`ifdef PCPI_ISSUER_STATS_EN
    ,
    .stat_issued     (stat_issued),
    .stat_timeouts   (stat_timeouts),
    .stat_busy_cycles(stat_busy_cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    return a * b;
  endfunction

  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [31:0] m_insn(input logic [2:0] f3);
    return {Func7MulDiv, 5'd12, 5'd11, f3, 5'd10, OpcodeOp};
  endfunction

  // Cycle index (0 = first cycle pcpi_valid is high) at which the issuer leaves for RESP.
  // Unclaimed: times out in cycle T-1. Claimed in cycle c: watchdog expires in cycle c+W.
  // A ready pulse at or before that cycle wins.
  function automatic int exit_cycle(input int c, input int r);
    int lim;
    lim = (c < 0 || c > T - 1) ? T - 1 : c + W;
    if (r >= 0 && r <= lim) return r;
    return lim;
  endfunction

  task automatic quiet_copro();
    pcpi_busy  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'd0;
  endtask

  // Issue one command and play the coprocessor: busy high from cycle c for blen cycles
  // (blen 0 = until exit, c < 0 = never), ready pulse in cycle r (r < 0 = never).
  // Called and returns at a negedge with the DUT idle.
  task automatic run_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int c, input int r, input int blen, input logic wr,
                        input logic [31:0] rd, input int stall);
    int            ex;
    logic          eerr;
    logic [31:0]   edata;
    logic          ewr;
    logic [CW-1:0] ecyc;
    ex    = exit_cycle(c, r);
    eerr  = (r != ex);
    edata = eerr ? 32'd0 : (wr ? rd : 32'd0);
    ewr   = eerr ? 1'b0 : wr;
    ecyc  = CW'(ex + 1);

    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_insn  = insn;
    cmd_rs1   = a;
    cmd_rs2   = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_insn  = $urandom;
    cmd_rs1   = $urandom;
    cmd_rs2   = $urandom;

    for (int k = 0; k <= ex; k++) begin
      chk("pcpi_valid_hi", pcpi_valid, 1'b1);
      chk("pcpi_insn", pcpi_insn, insn);
      chk("pcpi_rs1", pcpi_rs1, a);
      chk("pcpi_rs2", pcpi_rs2, b);
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      chk("rsp_valid_early", rsp_valid, 1'b0);
      pcpi_busy  = (c >= 0 && k >= c && (blen == 0 || k < c + blen));
      pcpi_ready = (k == r);
      pcpi_wr    = (k == r) ? wr : 1'($urandom);
      pcpi_rd    = (k == r) ? rd : $urandom;
      @(negedge clk);
    end

    // RESP: hold rsp_ready low for 'stall' cycles while noise is driven on every other input.
    for (int s = 0; s <= stall; s++) begin
      chk("pcpi_valid_lo", pcpi_valid, 1'b0);
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_data", rsp_data, edata);
      chk("rsp_wr", rsp_wr, ewr);
      chk("rsp_err", rsp_err, eerr);
      chk("rsp_cycles", rsp_cycles, ecyc);
      chk("cmd_ready_resp", cmd_ready, 1'b0);
      chk("pcpi_insn_hold", pcpi_insn, insn);
      rsp_ready  = (s == stall);
      cmd_valid  = 1'b1;
      cmd_insn   = $urandom;
      pcpi_busy  = 1'($urandom);
      pcpi_ready = 1'($urandom);
      pcpi_wr    = 1'($urandom);
      pcpi_rd    = $urandom;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    quiet_copro();
    // No bypass: the command offered on the handshake edge must not have been taken.
    chk("rsp_valid_done", rsp_valid, 1'b0);
    chk("cmd_ready_after", cmd_ready, 1'b1);
    chk("no_bypass_issue", pcpi_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b, rd;
    logic [2:0]  f3;
    int          c, r, blen;

    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_insn  = 32'd0;
    cmd_rs1   = 32'd0;
    cmd_rs2   = 32'd0;
    rsp_ready = 1'b0;
    quiet_copro();

    @(negedge clk);
    cur_tag = "reset";
    chk("cmd_ready", cmd_ready, 1'b0);
    chk("pcpi_valid", pcpi_valid, 1'b0);
    chk("pcpi_insn", pcpi_insn, 32'd0);
    chk("rsp_valid", rsp_valid, 1'b0);
    chk("rsp_data", rsp_data, 32'd0);
    chk("rsp_err", rsp_err, 1'b0);
    chk("rsp_cycles", rsp_cycles, 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Minimum latency: ready in the cycle after decode.
    cur_tag = "mul_7x6";
    run_op(32'h02C5_8533, 32'd7, 32'd6, -1, 1, 0, 1'b1, mul_ref(32'd7, 32'd6), 0);

    cur_tag = "div_m100_7";
    run_op(32'h02C5_C533, 32'hFFFF_FF9C, 32'd7, 1, 34, 0, 1'b1,
           div_ref(32'hFFFF_FF9C, 32'd7), 0);

    cur_tag = "unclaimed_add";
    run_op(32'h00C5_8533, 32'd1, 32'd2, -1, -1, 0, 1'b0, 32'd0, 0);

    cur_tag = "ready_at_timeout";
    run_op(m_insn(Func3Mul), 32'd9, 32'd9, -1, T - 1, 0, 1'b1, 32'd81, 0);

    cur_tag = "ready_after_timeout";
    run_op(m_insn(Func3Mul), 32'd9, 32'd9, -1, T, 0, 1'b1, 32'd81, 0);

    cur_tag = "hung_busy";
    run_op(m_insn(Func3Div), 32'd50, 32'd5, 1, -1, 0, 1'b1, 32'd10, 0);

    cur_tag = "ready_at_wdog";
    run_op(m_insn(Func3Div), 32'd50, 32'd5, 1, 1 + W, 0, 1'b1, 32'd10, 0);

    cur_tag = "busy_drops";
    run_op(m_insn(Func3Mul), 32'd4, 32'd4, 2, 20, 1, 1'b1, 32'd16, 0);

    cur_tag = "wr_low";
    run_op({7'h00, 5'd12, 5'd11, 3'b000, 5'd10, OpcodeCustom}, 32'd1, 32'd1, 0, 3, 0, 1'b0,
           32'hDEAD_BEEF, 0);

    cur_tag = "backpressure";
    run_op(32'h02C5_8533, 32'd12, 32'd11, 0, 2, 0, 1'b1, mul_ref(32'd12, 32'd11), 10);

    // Reset while the coprocessor is working on a divide.
    cur_tag = "reset_mid_busy";
    chk("cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_insn  = 32'h02C5_C533;
    cmd_rs1   = 32'd1000;
    cmd_rs2   = 32'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pcpi_busy = (k >= 1);
      @(negedge clk);
    end
    chk("pcpi_valid_pre", pcpi_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("pcpi_valid_async", pcpi_valid, 1'b0);
    chk("cmd_ready_in_rst", cmd_ready, 1'b0);
    chk("rsp_valid_in_rst", rsp_valid, 1'b0);
    quiet_copro();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rsp_valid_post", rsp_valid, 1'b0);
    chk("pcpi_valid_post", pcpi_valid, 1'b0);
    cur_tag = "mul_3x5_after_rst";
    run_op(32'h02C5_8533, 32'd3, 32'd5, -1, 1, 0, 1'b1, mul_ref(32'd3, 32'd5), 0);

    // Random operations, claim/ready timing and backpressure.
    for (int i = 0; i < 24; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      a    = $urandom;
      b    = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom;
      f3   = $urandom_range(0, 1) == 0 ? Func3Mul : Func3Div;
      rd   = (f3 == Func3Mul) ? mul_ref(a, b) : div_ref(a, b);
      c    = int'($urandom_range(0, 4)) - 1;
      r    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40));
      blen = int'($urandom_range(0, 2));
      run_op(m_insn(f3), a, b, c, r, blen, 1'($urandom), rd, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
